// File: rtl/input_channel_dequeue_scheduler_pkg.sv
// Shared definitions for the input-channel dequeue scheduler: channel count
// and the decode-occupancy state encoding.
package input_channel_dequeue_scheduler_pkg;

  // Number of input channels tracked by the PE.
  localparam int TIA_NUM_INPUT_CHANNELS = 4;

  // IDLE: decode empty; ISSUE: decode holds an instruction expected to retire;
  // HOLD: decode holds an instruction that was stalled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } dequeue_scheduler_state_t;

endpackage : input_channel_dequeue_scheduler_pkg

// File: rtl/input_channel_dequeue_scheduler.sv
// Input-channel dequeue scheduler.
// Captures the dequeue mask of each fired trigger, keeps it pending while the
// instruction sits in decode, and strobes the channel buffers when decode
// advances. The pending mask also folds into effective-empty flags so trigger
// resolution sees the buffers as a single-cycle pipeline would.
module input_channel_dequeue_scheduler
  import input_channel_dequeue_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS    = TIA_NUM_INPUT_CHANNELS,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       trigger_fire,
  input  logic [NUM_CHANNELS-1:0]    trigger_dequeue_mask,
  input  logic                       decode_stall,
  input  logic                       pipeline_flush,
  input  logic [NUM_CHANNELS-1:0]    channel_empty,
  input  logic [NUM_CHANNELS-1:0]    channel_next_valid,
  output logic                       trigger_ready,
  output logic [NUM_CHANNELS-1:0]    pending_dequeue_signals,
  output logic [NUM_CHANNELS-1:0]    dequeue_signals,
  output logic [NUM_CHANNELS-1:0]    effective_empty,
  output logic                       underflow_error,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

  dequeue_scheduler_state_t state_q, state_d;
  logic [NUM_CHANNELS-1:0]    pending_q, pending_d;
  logic                       underflow_q, underflow_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic decode_fire;
  logic accept;

  // Decode retire / trigger handshake and the strobes derived from the pending mask.
  always_comb begin
    decode_fire     = (state_q != IDLE) & ~decode_stall & ~pipeline_flush;
    trigger_ready   = (state_q == IDLE) | decode_fire;
    accept          = trigger_fire & trigger_ready & ~pipeline_flush;
    dequeue_signals = decode_fire ? pending_q : '0;
    effective_empty = channel_empty | (pending_q & ~channel_next_valid);
  end

  // Next state and pending mask; a flush wins over everything, and a new
  // accept replaces the pending mask rather than merging into it.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (pipeline_flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else if (accept) begin
      state_d   = decode_stall ? HOLD : ISSUE;
      pending_d = trigger_dequeue_mask;
    end else if (decode_fire) begin
      state_d   = IDLE;
      pending_d = '0;
    end else if ((state_q != IDLE) && decode_stall) begin
      state_d   = HOLD;
    end
  end

  // Sticky underflow flag and saturating count of cycles spent stalled in HOLD.
  always_comb begin
    underflow_d = underflow_q | (accept & (|(trigger_dequeue_mask & effective_empty)));
    stall_cnt_d = stall_cnt_q;
    if ((state_q == HOLD) && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  // State registers; reset drops any pending mask without issuing a dequeue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      underflow_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pending_dequeue_signals = pending_q;
  assign underflow_error         = underflow_q;
  assign stall_cycles            = stall_cnt_q;

endmodule : input_channel_dequeue_scheduler

// File: tb/tb_input_channel_dequeue_scheduler.sv
// Self-checking bench for input_channel_dequeue_scheduler. Expected dequeue
// strobes are queued as instructions are fired and matched by a monitor.
module tb_input_channel_dequeue_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         trigger_fire;
  logic [N-1:0] trigger_dequeue_mask;
  logic         decode_stall;
  logic         pipeline_flush;
  logic [N-1:0] channel_empty;
  logic [N-1:0] channel_next_valid;
  logic         trigger_ready;
  logic [N-1:0] pending_dequeue_signals;
  logic [N-1:0] dequeue_signals;
  logic [N-1:0] effective_empty;
  logic         underflow_error;
  logic [W-1:0] stall_cycles;

  logic [N-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  input_channel_dequeue_scheduler #(
    .NUM_CHANNELS(N),
    .STALL_CNT_WIDTH(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .trigger_fire(trigger_fire),
    .trigger_dequeue_mask(trigger_dequeue_mask),
    .decode_stall(decode_stall),
    .pipeline_flush(pipeline_flush),
    .channel_empty(channel_empty),
    .channel_next_valid(channel_next_valid),
    .trigger_ready(trigger_ready),
    .pending_dequeue_signals(pending_dequeue_signals),
    .dequeue_signals(dequeue_signals),
    .effective_empty(effective_empty),
    .underflow_error(underflow_error),
    .stall_cycles(stall_cycles)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every nonzero strobe must match the oldest queued mask.
  always @(negedge clock) begin
    if (reset === 1'b1 && dequeue_signals !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL dequeue_unexpected got=%b expected=none", dequeue_signals);
      end else begin
        logic [N-1:0] exp_mask;
        exp_mask = exp_q.pop_front();
        if (dequeue_signals !== exp_mask) begin
          failures++;
          $display("[TB] FAIL dequeue_strobe got=%b expected=%b", dequeue_signals, exp_mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset                = 1'b0;
    trigger_fire         = 1'b0;
    trigger_dequeue_mask = '0;
    decode_stall         = 1'b0;
    pipeline_flush       = 1'b0;
    channel_empty        = '0;
    channel_next_valid   = '1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_missing_dequeues got=%0d_outstanding expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if (trigger_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got=%b expected=1", trigger_ready);
    end
    checks++;
    if (pending_dequeue_signals !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_pending got=%b expected=0000", pending_dequeue_signals);
    end
    checks++;
    if (dequeue_signals !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_dequeue got=%b expected=0000", dequeue_signals);
    end
    checks++;
    if (underflow_error !== 1'b0 || stall_cycles !== 16'h0000) begin
      failures++; $display("[TB] FAIL reset_err_cnt got=%b/%h expected=0/0000", underflow_error, stall_cycles);
    end
  endtask

  task automatic test_single_issue();
    do_reset();
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0101;
    exp_q.push_back(4'b0101);
    tick();
    trigger_fire = 1'b0;
    @(negedge clock);
    checks++;
    if (pending_dequeue_signals !== 4'b0101 || dequeue_signals !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL single_issue got=%b/%b expected=0101/0101", pending_dequeue_signals, dequeue_signals);
    end
    tick();
    @(negedge clock);
    checks++;
    if (dequeue_signals !== 4'b0000 || trigger_ready !== 1'b1 || pending_dequeue_signals !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL single_idle got=%b/%b/%b expected=0000/1/0000", dequeue_signals, trigger_ready, pending_dequeue_signals);
    end
    check_drained("single");
  endtask

  task automatic test_stall();
    do_reset();
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    // Fires while not ready must be ignored.
    trigger_dequeue_mask = 4'b1000;
    decode_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (dequeue_signals !== 4'b0000 || trigger_ready !== 1'b0 || pending_dequeue_signals !== 4'b0010) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d got=%b/%b/%b expected=0000/0/0010", i, dequeue_signals, trigger_ready, pending_dequeue_signals);
      end
      tick();
    end
    trigger_fire = 1'b0; decode_stall = 1'b0;
    @(negedge clock);
    checks++;
    if (dequeue_signals !== 4'b0010) begin
      failures++; $display("[TB] FAIL stall_release got=%b expected=0010", dequeue_signals);
    end
    tick();
    @(negedge clock);
    checks++;
    if (stall_cycles !== 16'd3 || trigger_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_count got=%0d/%b expected=3/1", stall_cycles, trigger_ready);
    end
    check_drained("stall");
  endtask

  task automatic test_back_to_back();
    do_reset();
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0001;
    exp_q.push_back(4'b0001);
    @(negedge clock);
    checks++;
    if (trigger_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_ready0 got=%b expected=1", trigger_ready);
    end
    tick();
    trigger_dequeue_mask = 4'b1000;
    exp_q.push_back(4'b1000);
    @(negedge clock);
    checks++;
    if (trigger_ready !== 1'b1 || dequeue_signals !== 4'b0001) begin
      failures++; $display("[TB] FAIL b2b_first got=%b/%b expected=1/0001", trigger_ready, dequeue_signals);
    end
    tick();
    trigger_fire = 1'b0;
    @(negedge clock);
    checks++;
    if (trigger_ready !== 1'b1 || dequeue_signals !== 4'b1000 || pending_dequeue_signals !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL b2b_second got=%b/%b/%b expected=1/1000/1000", trigger_ready, dequeue_signals, pending_dequeue_signals);
    end
    tick();
    @(negedge clock);
    checks++;
    if (dequeue_signals !== 4'b0000) begin
      failures++; $display("[TB] FAIL b2b_idle got=%b expected=0000", dequeue_signals);
    end
    check_drained("b2b");
  endtask

  task automatic test_underflow();
    do_reset();
    channel_next_valid = 4'b1011;
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0100; decode_stall = 1'b1;
    exp_q.push_back(4'b0100);
    tick();
    trigger_fire = 1'b0;
    @(negedge clock);
    checks++;
    if (effective_empty !== 4'b0100 || underflow_error !== 1'b0) begin
      failures++; $display("[TB] FAIL uf_effective got=%b/%b expected=0100/0", effective_empty, underflow_error);
    end
    tick();
    decode_stall = 1'b0; trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    trigger_fire = 1'b0;
    @(negedge clock);
    checks++;
    if (underflow_error !== 1'b1) begin
      failures++; $display("[TB] FAIL uf_set got=%b expected=1", underflow_error);
    end
    repeat (3) tick();
    @(negedge clock);
    checks++;
    if (underflow_error !== 1'b1 || effective_empty !== 4'b0000) begin
      failures++; $display("[TB] FAIL uf_sticky got=%b/%b expected=1/0000", underflow_error, effective_empty);
    end
    check_drained("underflow");
  endtask

  task automatic test_flush();
    do_reset();
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0011; decode_stall = 1'b1;
    tick();
    trigger_dequeue_mask = 4'b1100; pipeline_flush = 1'b1; decode_stall = 1'b0;
    @(negedge clock);
    checks++;
    if (dequeue_signals !== 4'b0000 || pending_dequeue_signals !== 4'b0011) begin
      failures++; $display("[TB] FAIL flush_cycle got=%b/%b expected=0000/0011", dequeue_signals, pending_dequeue_signals);
    end
    tick();
    trigger_fire = 1'b0; pipeline_flush = 1'b0;
    @(negedge clock);
    checks++;
    if (pending_dequeue_signals !== 4'b0000 || trigger_ready !== 1'b1 || dequeue_signals !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL flush_after got=%b/%b/%b expected=0000/1/0000", pending_dequeue_signals, trigger_ready, dequeue_signals);
    end
    tick();
    // A fire arriving together with a flush while idle is dropped too.
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b1111; pipeline_flush = 1'b1;
    tick();
    trigger_fire = 1'b0; pipeline_flush = 1'b0;
    @(negedge clock);
    checks++;
    if (pending_dequeue_signals !== 4'b0000 || dequeue_signals !== 4'b0000) begin
      failures++; $display("[TB] FAIL flush_idle_drop got=%b/%b expected=0000/0000", pending_dequeue_signals, dequeue_signals);
    end
    check_drained("flush");
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    trigger_fire = 1'b1; trigger_dequeue_mask = 4'b0001; decode_stall = 1'b1;
    tick();
    trigger_fire = 1'b0;
    repeat (65541) tick();
    @(negedge clock);
    checks++;
    if (stall_cycles !== 16'hFFFF || trigger_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL sat_count got=%h/%b expected=ffff/0", stall_cycles, trigger_ready);
    end
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (trigger_ready !== 1'b1 || pending_dequeue_signals !== 4'b0000 || dequeue_signals !== 4'b0000 ||
        underflow_error !== 1'b0 || stall_cycles !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b/%b/%b/%b/%h expected=1/0000/0000/0/0000",
               trigger_ready, pending_dequeue_signals, dequeue_signals, underflow_error, stall_cycles);
    end
    tick();
    reset = 1'b1; decode_stall = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if (dequeue_signals !== 4'b0000 || trigger_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL post_reset got=%b/%b expected=0000/1", dequeue_signals, trigger_ready);
    end
    check_drained("saturate");
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_stall();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_input_channel_dequeue_scheduler
